matrix_loader: RTL and testbench
================================

// Module: matrix_loader
// PURPOSE
//  Upstream feeder for matrix_mult_parallel. Accepts a serial valid/ready stream of 32-bit
//  elements, A row-major first then B row-major, into register banks. Presents A and B,
//  with matrix_size, as flattened parallel buses to the multiplier. Holds them stable until
//  the consumer acknowledges the product, then rearms for the next pair.
// PARAMETERS
//  MAX_SIZE  10  maximum matrix dimension N; banks are MAX_SIZE x MAX_SIZE
//  DATA_W    32  element width in bits
// PORTS
//  clk          in   1                       rising-edge clock
//  rst_n        in   1                       asynchronous active-low reset
//  start        in   1                       begin a load; sampled in IDLE only
//  size_in      in   32                      N for this load; captured on accepted start
//  s_data       in   DATA_W                  stream element
//  s_valid      in   1                       s_data valid
//  s_ready      out  1                       loader accepts s_data this cycle
//  matrix_size  out  32                      captured N, to multiplier
//  a_flat       out  MAX_SIZE*MAX_SIZE*DATA_W  A[i][j] at bits [(i*MAX_SIZE+j)*DATA_W +: DATA_W]
//  b_flat       out  MAX_SIZE*MAX_SIZE*DATA_W  B, same packing as a_flat
//  mat_valid    out  1                       A/B complete and stable; multiplier output valid
//  mat_ack      in   1                       consumer has taken the product; release
//  busy         out  1                       high in every state except IDLE
//  err          out  1                       one-cycle pulse: start rejected for bad size
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; s_ready=0, mat_valid=0, busy=0, err=0,
//   matrix_size=0, a_flat=0, b_flat=0, row/col counters=0.
//  States: IDLE -> LOAD_A -> LOAD_B -> HOLD -> IDLE.
//  IDLE: start=1 and 1<=size_in<=MAX_SIZE -> capture size, clear both banks to 0, go to LOAD_A.
//   start=1 with size_in==0 or size_in>MAX_SIZE -> err=1 for one cycle, stay in IDLE.
//  LOAD_A/LOAD_B: s_ready=1. Transfer occurs only when s_valid&&s_ready.
//   Each transfer writes element [row][col] of the current bank, then increments col.
//   col==N-1 wraps col to 0 and increments row.
//   Transfer with row==N-1 and col==N-1: clear counters, advance to the next state.
//   No transfer (s_valid=0) -> counters and banks hold. There is no timeout.
//   Exactly 2*N*N transfers per load; elements outside NxN stay 0.
//  HOLD: s_ready=0, mat_valid=1. Banks and matrix_size are frozen.
//   mat_valid rises on the first clk edge after the final B transfer, i.e. 1-cycle latency.
//   mat_ack=1 -> next cycle IDLE, mat_valid=0. Banks keep their contents until the next accepted start.
//  start outside IDLE is ignored; no err pulse. mat_ack outside HOLD is ignored.
//  mat_ack and start both high in HOLD: go to IDLE only; that start is not captured.
//  Reset mid-load or in HOLD: immediate return to IDLE with all outputs at reset values.
//   The partial load is discarded.
//  Size compare is unsigned 32-bit. Counters are $clog2(MAX_SIZE) bits wide.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1. N=3; stream A=1..9, then B=9..1, s_valid held high -> s_ready high for 18 cycles.
//     mat_valid rises 1 cycle after the 18th transfer. Multiplier C row0 = 30 24 18,
//     row1 = 84 69 54, row2 = 138 114 90.
//  2. Same data with s_valid toggling every other cycle -> identical banks.
//     mat_valid after 18 transfers, not after 18 cycles.
//  3. start with size_in=0 and then size_in=11 -> err pulses once each; busy stays 0; s_ready stays 0.
//  4. N=3 load following an N=10 load -> indices >=3 of both banks read 0.
//  5. Assert rst_n=0 after 5 transfers of A -> next cycle all outputs are 0 and state is IDLE.
//     A fresh N=2 load then completes correctly.
//  6. N=1, A=7, B=6 -> mat_valid after 2 transfers, C[0][0]=42.
//     start during HOLD is ignored; mat_ack -> mat_valid=0 next cycle.

Source files
------------

// File: rtl/matrix_loader_if.sv
// Bus between the serial element stream, the loader and the parallel matrix consumer.
// Stream handshake: an element moves on a rising clk edge exactly when s_valid && s_ready.
interface matrix_loader_if #(
    parameter int MAX_SIZE = 10,
    parameter int DATA_W   = 32
);
    localparam int FLAT_W = MAX_SIZE * MAX_SIZE * DATA_W;

    logic              start;
    logic [31:0]       size_in;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       matrix_size;
    logic [FLAT_W-1:0] a_flat;
    logic [FLAT_W-1:0] b_flat;
    logic              mat_valid;
    logic              mat_ack;
    logic              busy;
    logic              err;

    modport master (
        output start, size_in, s_data, s_valid, mat_ack,
        input  s_ready, matrix_size, a_flat, b_flat, mat_valid, busy, err
    );

    modport slave (
        input  start, size_in, s_data, s_valid, mat_ack,
        output s_ready, matrix_size, a_flat, b_flat, mat_valid, busy, err
    );
endinterface

// File: rtl/matrix_loader.sv
// Collects A then B (row-major) from a serial stream into register banks and presents
// them in parallel with the captured size until the consumer acknowledges.
module matrix_loader #(
    parameter int MAX_SIZE = 10,
    parameter int DATA_W   = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    matrix_loader_if.slave bus,
    output logic [1:0]     state_o
);
    localparam int CW = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
    localparam int NE = MAX_SIZE * MAX_SIZE;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [CW-1:0]     last_q;
    logic [31:0]       size_q;
    logic              s_ready_q;
    logic              mat_valid_q;
    logic              busy_q;
    logic              err_q;
    logic [DATA_W-1:0] a_bank_q [NE];
    logic [DATA_W-1:0] b_bank_q [NE];

    logic [IW-1:0]     idx;
    logic              size_ok;
    logic              xfer;

    always_comb begin
        idx     = IW'(row_q) * IW'(MAX_SIZE) + IW'(col_q);
        size_ok = (bus.size_in != 32'd0) && (bus.size_in <= 32'(MAX_SIZE));
        xfer    = bus.s_valid && s_ready_q;
    end

    // s_ready_q is high exactly in LOAD_A/LOAD_B, so xfer implies a load state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            last_q      <= '0;
            size_q      <= '0;
            s_ready_q   <= 1'b0;
            mat_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int k = 0; k < NE; k++) begin
                a_bank_q[k] <= '0;
                b_bank_q[k] <= '0;
            end
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (size_ok) begin
                            size_q    <= bus.size_in;
                            last_q    <= CW'(bus.size_in - 32'd1);
                            row_q     <= '0;
                            col_q     <= '0;
                            s_ready_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= LOAD_A;
                            for (int k = 0; k < NE; k++) begin
                                a_bank_q[k] <= '0;
                                b_bank_q[k] <= '0;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (xfer) begin
                        if (state_q == LOAD_A) a_bank_q[idx] <= bus.s_data;
                        else                   b_bank_q[idx] <= bus.s_data;
                        if (col_q == last_q) begin
                            col_q <= '0;
                            if (row_q == last_q) begin
                                row_q <= '0;
                                if (state_q == LOAD_A) begin
                                    state_q <= LOAD_B;
                                end else begin
                                    state_q     <= HOLD;
                                    s_ready_q   <= 1'b0;
                                    mat_valid_q <= 1'b1;
                                end
                            end else begin
                                row_q <= row_q + CW'(1);
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.mat_ack) begin
                        state_q     <= IDLE;
                        mat_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.mat_valid   = mat_valid_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;
    assign bus.matrix_size = size_q;
    assign state_o         = state_q;

    for (genvar g = 0; g < NE; g++) begin : g_flat
        assign bus.a_flat[g*DATA_W +: DATA_W] = a_bank_q[g];
        assign bus.b_flat[g*DATA_W +: DATA_W] = b_bank_q[g];
    end
endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: transfer-count reference model compared every negedge,
// plus hand-computed literal expectations for the directed scenarios.
module tb_matrix_loader;
    localparam int MS = 10;
    localparam int DW = 32;
    localparam int NE = MS * MS;
    localparam int FW = NE * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] state_dbg;
    always #5 clk = ~clk;

    matrix_loader_if #(.MAX_SIZE(MS), .DATA_W(DW)) bus ();

    matrix_loader #(.MAX_SIZE(MS), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Elements still to be streamed; the model pops one per accepted transfer.
    logic [DW-1:0] exp_q[$];

    bit            m_load, m_hold, m_err;
    int            m_cnt;
    int unsigned   m_n;
    logic [DW-1:0] m_a [NE];
    logic [DW-1:0] m_b [NE];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_load = 0; m_hold = 0; m_err = 0; m_cnt = 0; m_n = 0;
            for (int k = 0; k < NE; k++) begin m_a[k] = '0; m_b[k] = '0; end
        end else begin
            m_err = 0;
            if (m_hold) begin
                if (bus.mat_ack) m_hold = 0;
            end else if (m_load) begin
                if (bus.s_valid) begin
                    int t;
                    t = m_cnt;
                    if (t < int'(m_n * m_n)) m_a[(t / m_n) * MS + t % m_n] = bus.s_data;
                    else begin
                        t = t - int'(m_n * m_n);
                        m_b[(t / m_n) * MS + t % m_n] = bus.s_data;
                    end
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    m_cnt++;
                    if (m_cnt == int'(2 * m_n * m_n)) begin m_load = 0; m_hold = 1; end
                end
            end else if (bus.start) begin
                if (bus.size_in >= 1 && bus.size_in <= MS) begin
                    m_n = bus.size_in; m_cnt = 0; m_load = 1;
                    for (int k = 0; k < NE; k++) begin m_a[k] = '0; m_b[k] = '0; end
                end else m_err = 1;
            end
        end
    end

    function automatic logic [63:0] c_elem(input int i, input int j);
        logic [63:0] s;
        s = 0;
        for (int k = 0; k < int'(m_n); k++) s += 64'(m_a[i*MS+k]) * 64'(m_b[k*MS+j]);
        return s;
    endfunction

    function automatic logic [DW-1:0] elem(input logic [FW-1:0] f, input int i, input int j);
        return f[(i*MS+j)*DW +: DW];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_bank(input string nm, input logic [FW-1:0] flat, input logic [DW-1:0] arr [NE]);
        bit bad;
        bad = 0;
        n_checks++;
        for (int k = 0; k < NE; k++) begin
            if (!bad && flat[k*DW +: DW] !== arr[k]) begin
                bad = 1;
                $display("FAIL %s[%0d] act=%0h exp=%0h t=%0t", nm, k, flat[k*DW +: DW], arr[k], $time);
            end
        end
        if (bad) n_errors++;
    endtask

    int rdy_cycles = 0;
    int err_pulses = 0;
    always @(negedge clk) begin
        chk("s_ready", 32'(bus.s_ready), 32'(m_load));
        chk("busy", 32'(bus.busy), 32'(m_load | m_hold));
        chk("mat_valid", 32'(bus.mat_valid), 32'(m_hold));
        chk("err", 32'(bus.err), 32'(m_err));
        chk("matrix_size", bus.matrix_size, m_n);
        chk_bank("a_flat", bus.a_flat, m_a);
        chk_bank("b_flat", bus.b_flat, m_b);
        if (bus.s_ready) rdy_cycles++;
        if (bus.err) err_pulses++;
    end

    task automatic do_start(input logic [31:0] sz);
        bus.start = 1'b1; bus.size_in = sz;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.size_in = $urandom;
    endtask

    // mode 0: valid always high, 1: valid every other cycle, 2: random valid
    task automatic stream(input int mode);
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 2000) begin
            case (mode)
                0:       bus.s_valid = 1'b1;
                1:       bus.s_valid = (budget % 2 == 0);
                default: bus.s_valid = 1'($urandom_range(0, 1));
            endcase
            bus.s_data = exp_q[0];
            @(posedge clk); #1;
            budget++;
        end
        bus.s_valid = 1'b0; bus.s_data = $urandom;
        chk("stream_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_valid();
        int budget;
        budget = 0;
        while (!bus.mat_valid && budget < 20) begin @(posedge clk); #1; budget++; end
        chk("wait_mat_valid", 32'(bus.mat_valid), 32'd1);
    endtask

    task automatic ack();
        bus.mat_ack = 1'b1;
        @(posedge clk); #1;
        bus.mat_ack = 1'b0;
        chk("ack_release", 32'(bus.mat_valid), 32'd0);
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k < 2*n*n; k++) exp_q.push_back($urandom);
    endtask

    initial begin
        bus.start = 0; bus.size_in = 0; bus.s_data = 0; bus.s_valid = 0; bus.mat_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_s_ready", 32'(bus.s_ready), 0);
        chk("rst_size", bus.matrix_size, 0);
        chk("rst_a00", elem(bus.a_flat, 0, 0), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // N=3, A=1..9, B=9..1, valid held high
        for (int k = 1; k <= 9; k++) exp_q.push_back(k);
        for (int k = 9; k >= 1; k--) exp_q.push_back(k);
        rdy_cycles = 0;
        do_start(3);
        stream(0);
        chk("t1_latency", 32'(bus.mat_valid), 1);
        chk("t1_ready_cycles", rdy_cycles, 18);
        chk("t1_c00", c_elem(0, 0)[31:0], 30);  chk("t1_c01", c_elem(0, 1)[31:0], 24);
        chk("t1_c02", c_elem(0, 2)[31:0], 18);  chk("t1_c10", c_elem(1, 0)[31:0], 84);
        chk("t1_c11", c_elem(1, 1)[31:0], 69);  chk("t1_c12", c_elem(1, 2)[31:0], 54);
        chk("t1_c20", c_elem(2, 0)[31:0], 138); chk("t1_c21", c_elem(2, 1)[31:0], 114);
        chk("t1_c22", c_elem(2, 2)[31:0], 90);
        chk("t1_a12", elem(bus.a_flat, 1, 2), 6);
        chk("t1_b22", elem(bus.b_flat, 2, 2), 1);
        chk("t1_size", bus.matrix_size, 3);
        ack();

        // Same data, valid toggling
        for (int k = 1; k <= 9; k++) exp_q.push_back(k);
        for (int k = 9; k >= 1; k--) exp_q.push_back(k);
        do_start(3);
        stream(1);
        chk("t2_valid", 32'(bus.mat_valid), 1);
        chk("t2_a00", elem(bus.a_flat, 0, 0), 1);
        chk("t2_b00", elem(bus.b_flat, 0, 0), 9);
        chk("t2_b21", elem(bus.b_flat, 2, 1), 2);
        ack();

        // Bad sizes
        err_pulses = 0;
        do_start(0);
        chk("t3_err0", 32'(bus.err), 1);
        chk("t3_busy0", 32'(bus.busy), 0);
        @(posedge clk); #1;
        chk("t3_err0_clear", 32'(bus.err), 0);
        do_start(11);
        chk("t3_err11", 32'(bus.err), 1);
        chk("t3_ready11", 32'(bus.s_ready), 0);
        do_start(32'hFFFF_FFFF);
        chk("t3_errmax", 32'(bus.err), 1);
        @(posedge clk); #1;
        chk("t3_pulses", err_pulses, 3);

        // N=10 then N=3: upper indices cleared
        fill_random(10);
        do_start(10);
        stream(2);
        wait_valid();
        ack();
        fill_random(3);
        do_start(3);
        stream(0);
        chk("t4_a33", elem(bus.a_flat, 3, 3), 0);
        chk("t4_a09", elem(bus.a_flat, 0, 9), 0);
        chk("t4_b90", elem(bus.b_flat, 9, 0), 0);
        chk("t4_b99", elem(bus.b_flat, 9, 9), 0);
        ack();

        // Reset after 5 transfers of A, then fresh N=2 load
        fill_random(4);
        do_start(4);
        bus.s_valid = 1'b1;
        repeat (5) begin bus.s_data = exp_q[0]; @(posedge clk); #1; end
        rst_n = 1'b0; bus.s_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_ready", 32'(bus.s_ready), 0);
        chk("t5_size", bus.matrix_size, 0);
        chk("t5_a00", elem(bus.a_flat, 0, 0), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 8; k++) exp_q.push_back(k);
        do_start(2);
        stream(2);
        wait_valid();
        chk("t5_c00", c_elem(0, 0)[31:0], 19); chk("t5_c01", c_elem(0, 1)[31:0], 22);
        chk("t5_c10", c_elem(1, 0)[31:0], 43); chk("t5_c11", c_elem(1, 1)[31:0], 50);
        chk("t5_b11", elem(bus.b_flat, 1, 1), 8);
        ack();

        // N=1, start ignored in HOLD, ack together with start
        exp_q.push_back(7); exp_q.push_back(6);
        do_start(1);
        stream(0);
        chk("t6_valid", 32'(bus.mat_valid), 1);
        chk("t6_c00", c_elem(0, 0)[31:0], 42);
        do_start(2);
        chk("t6_hold_valid", 32'(bus.mat_valid), 1);
        chk("t6_hold_size", bus.matrix_size, 1);
        chk("t6_hold_err", 32'(bus.err), 0);
        bus.mat_ack = 1'b1; bus.start = 1'b1; bus.size_in = 2;
        @(posedge clk); #1;
        bus.mat_ack = 1'b0; bus.start = 1'b0;
        chk("t6_ack_valid", 32'(bus.mat_valid), 0);
        chk("t6_ack_busy", 32'(bus.busy), 0);
        chk("t6_ack_a00", elem(bus.a_flat, 0, 0), 7);
        @(posedge clk); #1;

        // Randomized loads
        for (int it = 0; it < 6; it++) begin
            int n;
            n = $urandom_range(1, MS);
            fill_random(n);
            do_start(n);
            stream($urandom_range(0, 2));
            wait_valid();
            repeat ($urandom_range(0, 3)) begin
                bus.start = 1'($urandom_range(0, 1)); bus.size_in = $urandom_range(0, 12);
                @(posedge clk); #1;
            end
            bus.start = 1'b0;
            ack();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
